// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer.
// Mode encodings and a width helper that never returns zero.
package mux_pkg;

  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_FIX = 1'b1;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter.
// Searches req from ptr upward, wrapping modulo NUM_CH.
module rr_arb
  import mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              any
);

  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt_idx  = SEL_W'(idx);
        gnt[idx] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux_stream_rr.sv
// N-channel valid/ready stream mux with a registered output.
// Round-robin or fixed-select arbitration into one beat register.
module mux_stream_rr
  import mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = clog2_min1(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
);

  logic [NUM_CH-1:0] fix_mask;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] gnt;
  logic [SEL_W-1:0]  gnt_idx;
  logic              any;
  logic              load;
  logic [DATA_W-1:0] gnt_data;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [SEL_W-1:0]  out_ch_q;

  // Out-of-range sel matches no bit, so nothing is eligible.
  always_comb begin
    fix_mask = '0;
    for (int i = 0; i < NUM_CH; i++)
      fix_mask[i] = (int'(sel) == i);
  end

  assign elig = (mode == MODE_FIX) ? (in_valid & fix_mask)
                                   : in_valid;

  rr_arb #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req     (elig),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign load     = !out_valid_q || out_ready;
  assign in_ready = (load && rst_n) ? gnt : '0;

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (gnt[i]) gnt_data = in_data[i*DATA_W +: DATA_W];
  end

  assign ptr_d = (gnt_idx == SEL_W'(NUM_CH - 1)) ? '0
                                                 : gnt_idx + SEL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else if (load) begin
      out_valid_q <= any;
      if (any) begin
        out_data_q <= gnt_data;
        out_ch_q   <= gnt_idx;
        if (mode == MODE_RR) ptr_q <= ptr_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule
